// File: rtl/ext_if.sv
// Decode-to-execute immediate extension bus.
// The extension unit is the slave: it receives the immediate and the opcode, and drives the registered result.
interface ext_if;
  logic        en;
  logic [15:0] imm;
  logic [1:0]  EOp;
  logic [31:0] ext;
  logic        ext_valid;
  logic        ext_neg;

  modport master (
    output en,
    output imm,
    output EOp,
    input  ext,
    input  ext_valid,
    input  ext_neg
  );

  modport slave (
    input  en,
    input  imm,
    input  EOp,
    output ext,
    output ext_valid,
    output ext_neg
  );
endinterface

// File: rtl/ext.sv
// Immediate-extension unit: extends the 16-bit immediate to 32 bits (zero, sign, upper, branch offset).
// The result is registered once. A valid flag and a sign copy are registered with it.
module ext (
  input  logic clk,
  input  logic reset,
  ext_if.slave bus
);

  function automatic logic [31:0] extend(input logic [15:0] val, input logic [1:0] op);
    logic signed [31:0] sx;
    sx = {{16{val[15]}}, val};
    case (op)
      2'b00:   extend = {16'h0000, val};
      2'b01:   extend = sx;
      2'b10:   extend = {val, 16'h0000};
      default: extend = {sx[29:0], 2'b00};
    endcase
  endfunction

  logic [31:0] ext_q, ext_d;
  logic        neg_q, neg_d;
  logic        vld_q, vld_d;
  logic [31:0] r;

  // stage 0: combinational extension of the current inputs
  always_comb begin
    r     = extend(bus.imm, bus.EOp);
    ext_d = ext_q;
    neg_d = neg_q;
    vld_d = 1'b0;
    if (bus.en) begin
      ext_d = r;
      neg_d = r[31];
      vld_d = 1'b1;
    end
  end

  // stage 1: output register; a stalled cycle holds the data but drops valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q <= 32'h0000_0000;
      neg_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      neg_q <= neg_d;
      vld_q <= vld_d;
    end
  end

  assign bus.ext       = ext_q;
  assign bus.ext_neg   = neg_q;
  assign bus.ext_valid = vld_q;

endmodule

// File: tb/tb_ext.sv
// Bench for the immediate-extension unit: fixed vectors, hold and reset sequences, then randomized traffic.
// The randomized traffic is checked against an arithmetic reference model.
module tb_ext;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ext_if bus();

  ext dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  op;
    logic [31:0] exp;
    logic        neg;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [31:0] model(input logic [15:0] i, input logic [1:0] op);
    int s;
    int u;
    s = int'($signed(i));
    u = int'(i);
    case (op)
      2'd0:    return 32'(u);
      2'd1:    return 32'(s);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [31:0] e_ext, input logic e_neg, input logic e_vld);
    chk({name, ".ext"}, bus.ext, e_ext);
    chk({name, ".neg"}, {31'b0, bus.ext_neg}, {31'b0, e_neg});
    chk({name, ".valid"}, {31'b0, bus.ext_valid}, {31'b0, e_vld});
  endtask

  // apply inputs, then cross one rising edge and land 1 time unit after it
  task automatic step(input logic e, input logic [15:0] i, input logic [1:0] op);
    bus.en  = e;
    bus.imm = i;
    bus.EOp = op;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] m_ext;
  logic        m_vld;
  logic        r_en;
  logic [15:0] r_imm;
  logic [1:0]  r_op;

  initial begin
    checks   = 0;
    failures = 0;
    tbl[0]  = '{16'hF0F0, 2'd0, 32'h0000F0F0, 1'b0};
    tbl[1]  = '{16'hF0F0, 2'd1, 32'hFFFFF0F0, 1'b1};
    tbl[2]  = '{16'hF0F0, 2'd2, 32'hF0F00000, 1'b1};
    tbl[3]  = '{16'hF0F0, 2'd3, 32'hFFFFC3C0, 1'b1};
    tbl[4]  = '{16'h1234, 2'd1, 32'h00001234, 1'b0};
    tbl[5]  = '{16'h1234, 2'd3, 32'h000048D0, 1'b0};
    tbl[6]  = '{16'h8000, 2'd1, 32'hFFFF8000, 1'b1};
    tbl[7]  = '{16'h7FFF, 2'd3, 32'h0001FFFC, 1'b0};
    tbl[8]  = '{16'hFFFF, 2'd2, 32'hFFFF0000, 1'b1};
    tbl[9]  = '{16'h0000, 2'd0, 32'h00000000, 1'b0};
    tbl[10] = '{16'h0000, 2'd1, 32'h00000000, 1'b0};
    tbl[11] = '{16'h0000, 2'd2, 32'h00000000, 1'b0};
    tbl[12] = '{16'h0000, 2'd3, 32'h00000000, 1'b0};
    tbl[13] = '{16'h8001, 2'd3, 32'hFFFE0004, 1'b1};

    // reset, then idle with en low
    reset   = 1'b1;
    bus.en  = 1'b1;
    bus.imm = 16'hFFFF;
    bus.EOp = 2'd1;
    #2;
    chk_out("reset_async", 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("reset_en_ignored", 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 16'hABCD, 2'd1);
    chk_out("idle0", 32'h0, 1'b0, 1'b0);
    step(1'b0, 16'h5555, 2'd2);
    chk_out("idle1", 32'h0, 1'b0, 1'b0);

    // back-to-back captures from the vector table
    for (int k = 0; k < 14; k++) begin
      step(1'b1, tbl[k].imm, tbl[k].op);
      chk_out($sformatf("vec%0d", k), tbl[k].exp, tbl[k].neg, 1'b1);
    end

    // capture, then hold for three cycles while the inputs keep moving
    step(1'b1, 16'hF0F0, 2'd1);
    chk_out("hold_cap", 32'hFFFFF0F0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 16'(k * 16'h1111 + 16'h0F0F), 2'(k));
      chk_out($sformatf("hold%0d", k), 32'hFFFFF0F0, 1'b1, 1'b0);
    end

    // reset asserted between edges while capturing continuously
    step(1'b1, 16'h8000, 2'd2);
    chk_out("pre_rst", 32'h80000000, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_out("mid_rst", 32'h0, 1'b0, 1'b0);
    step(1'b1, 16'h7777, 2'd1);
    chk_out("in_rst", 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b1, 16'h1234, 2'd3);
    chk_out("post_rst", 32'h000048D0, 1'b0, 1'b1);

    // randomized traffic against the reference model
    m_ext = 32'h000048D0;
    m_vld = 1'b1;
    for (int k = 0; k < 300; k++) begin
      r_en  = ($urandom_range(0, 3) != 0);
      r_imm = 16'($urandom);
      r_op  = 2'($urandom_range(0, 3));
      if (r_en) m_ext = model(r_imm, r_op);
      m_vld = r_en;
      step(r_en, r_imm, r_op);
      bus.imm = ~r_imm;
      bus.EOp = ~r_op;
      #2;
      chk_out($sformatf("rnd%0d", k), m_ext, m_ext[31], m_vld);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
